// File: rtl/core_pkg.sv
// Shared RV32I core constants: sequencer state encodings, writeback selects and trap causes.
// The decoder and datapath import the same definitions.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM    = 2'd2,
    CAUSE_DMEM    = 2'd3
  } trap_cause_t;

  // Loads reach memory through the writeback mux, stores through MemRW.
  function automatic logic needs_mem(input logic memrw, input logic [1:0] wbsel);
    return memrw | (wbsel == WB_MEM);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait counter shared by FETCH and MEM; flags when MAX_WAIT stalled cycles have elapsed.
// MAX_WAIT of zero never expires.
module wait_timer #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  logic [W-1:0] r_count;

  // Saturating count so a disabled timeout cannot wrap back into a match.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = (MAX_WAIT != 0) && (r_count == W'(MAX_WAIT));

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer: freezes the decoder bundle in DECODE,
// gates state-changing strobes to their phase and traps on illegal opcodes or memory timeouts.
module ctrl_sequencer
  import core_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             illegal,
  input  logic             PCSel_d,
  input  logic             RegWEn_d,
  input  logic             ASel_d,
  input  logic             BSel_d,
  input  logic             MemRW_d,
  input  logic [2:0]       DataRSel_d,
  input  logic [2:0]       ImmSel_d,
  input  logic [1:0]       DataWSel_d,
  input  logic [1:0]       WBSel_d,
  input  logic [3:0]       ALUSel_d,
  output logic             PCSel,
  output logic             ASel,
  output logic             BSel,
  output logic [2:0]       DataRSel,
  output logic [2:0]       ImmSel,
  output logic [1:0]       DataWSel,
  output logic [1:0]       WBSel,
  output logic [3:0]       ALUSel,
  output logic             RegWEn,
  output logic             MemRW,
  output logic             ir_we,
  output logic             pc_we,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  trap_cause_t      r_trap_cause;
  logic             r_trap;
  logic [CNT_W-1:0] r_retired;
  logic             r_pcsel, r_regwen, r_asel, r_bsel, r_memrw;
  logic [2:0]       r_datarsel, r_immsel;
  logic [1:0]       r_datawsel, r_wbsel;
  logic [3:0]       r_alusel;

  logic w_in_fetch, w_in_mem, w_timer_clear, w_timer_en, w_expired;

  assign w_in_fetch    = (r_state == ST_FETCH);
  assign w_in_mem      = (r_state == ST_MEM);
  // Held at zero outside the two wait states, so each FETCH/MEM visit starts from a fresh count.
  assign w_timer_clear = !(w_in_fetch || w_in_mem);
  assign w_timer_en    = (w_in_fetch && !imem_ready) || (w_in_mem && !dmem_ready);

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_timer_clear),
    .i_en     (w_timer_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_trap       <= 1'b0;
      r_trap_cause <= CAUSE_NONE;
      r_retired    <= '0;
      r_pcsel      <= 1'b0;
      r_regwen     <= 1'b0;
      r_asel       <= 1'b0;
      r_bsel       <= 1'b0;
      r_memrw      <= 1'b0;
      r_datarsel   <= 3'd0;
      r_immsel     <= 3'd0;
      r_datawsel   <= 2'd0;
      r_wbsel      <= 2'd0;
      r_alusel     <= 4'd0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            r_state <= ST_DECODE;
          end else if (w_expired) begin
            r_state      <= ST_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= CAUSE_IMEM;
          end
        end
        ST_DECODE: begin
          r_pcsel    <= PCSel_d;
          r_regwen   <= RegWEn_d;
          r_asel     <= ASel_d;
          r_bsel     <= BSel_d;
          r_memrw    <= MemRW_d;
          r_datarsel <= DataRSel_d;
          r_immsel   <= ImmSel_d;
          r_datawsel <= DataWSel_d;
          r_wbsel    <= WBSel_d;
          r_alusel   <= ALUSel_d;
          if (illegal) begin
            r_state      <= ST_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= CAUSE_ILLEGAL;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= needs_mem(r_memrw, r_wbsel) ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready) begin
            r_state <= ST_WB;
          end else if (w_expired) begin
            r_state      <= ST_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= CAUSE_DMEM;
          end
        end
        ST_WB: begin
          r_retired <= r_retired + CNT_W'(1);
          r_state   <= ST_FETCH;
        end
        ST_TRAP: begin
          r_state <= ST_TRAP;
        end
        default: begin
          r_state      <= ST_TRAP;
          r_trap       <= 1'b1;
          r_trap_cause <= CAUSE_ILLEGAL;
        end
      endcase
    end
  end

  assign PCSel    = r_pcsel;
  assign ASel     = r_asel;
  assign BSel     = r_bsel;
  assign DataRSel = r_datarsel;
  assign ImmSel   = r_immsel;
  assign DataWSel = r_datawsel;
  assign WBSel    = r_wbsel;
  assign ALUSel   = r_alusel;

  // Phase-gated strobes decode straight from the state register.
  assign RegWEn   = r_regwen && (r_state == ST_WB);
  assign MemRW    = r_memrw && w_in_mem;
  assign ir_we    = w_in_fetch && imem_ready;
  assign pc_we    = (r_state == ST_WB);
  assign imem_req = w_in_fetch;
  assign dmem_req = w_in_mem;

  assign trap       = r_trap;
  assign trap_cause = r_trap_cause;
  assign state_o    = r_state;
  assign retired    = r_retired;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus predicts each state transition into a queue,
// a negedge monitor pops on every transition and checks strobes and held bundle every cycle.
module tb_ctrl_sequencer;

  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, illegal = 1'b0;
  logic PCSel_d = 1'b0, RegWEn_d = 1'b0, ASel_d = 1'b0, BSel_d = 1'b0, MemRW_d = 1'b0;
  logic [2:0] DataRSel_d = 3'd0, ImmSel_d = 3'd0;
  logic [1:0] DataWSel_d = 2'd0, WBSel_d = 2'd0;
  logic [3:0] ALUSel_d = 4'd0;
  logic PCSel, ASel, BSel, RegWEn, MemRW, ir_we, pc_we, imem_req, dmem_req, trap;
  logic [2:0] DataRSel, ImmSel, state_o;
  logic [1:0] DataWSel, WBSel, trap_cause;
  logic [3:0] ALUSel, retired;

  ctrl_sequencer #(.MAX_WAIT(MAXW), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .dmem_ready(dmem_ready), .illegal(illegal),
    .PCSel_d(PCSel_d), .RegWEn_d(RegWEn_d), .ASel_d(ASel_d), .BSel_d(BSel_d), .MemRW_d(MemRW_d),
    .DataRSel_d(DataRSel_d), .ImmSel_d(ImmSel_d), .DataWSel_d(DataWSel_d), .WBSel_d(WBSel_d),
    .ALUSel_d(ALUSel_d), .PCSel(PCSel), .ASel(ASel), .BSel(BSel), .DataRSel(DataRSel),
    .ImmSel(ImmSel), .DataWSel(DataWSel), .WBSel(WBSel), .ALUSel(ALUSel), .RegWEn(RegWEn),
    .MemRW(MemRW), .ir_we(ir_we), .pc_we(pc_we), .imem_req(imem_req), .dmem_req(dmem_req),
    .trap(trap), .trap_cause(trap_cause), .state_o(state_o), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_reset;
    logic [2:0] st;
    int         dwell;
    logic       tr;
    logic [1:0] cause;
    logic [3:0] ret;
    logic       regwen;
    logic       memrw;
    logic [16:0] bundle;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model of what the sequencer should be holding.
  logic [16:0] m_bundle = 17'd0;
  logic [3:0]  m_ret = 4'd0;
  logic        m_regwen = 1'b0, m_memrw = 1'b0;

  logic [16:0] act_bundle;
  assign act_bundle = {PCSel, ASel, BSel, DataRSel, ImmSel, DataWSel, WBSel, ALUSel};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_rst, input logic [2:0] st, input int dwell,
                      input logic tr, input logic [1:0] cause);
    exp_t e;
    e.is_reset = is_rst; e.st = st; e.dwell = dwell; e.tr = tr; e.cause = cause;
    e.ret = m_ret; e.regwen = m_regwen; e.memrw = m_memrw; e.bundle = m_bundle;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bundle/strobe inputs that must be ignored outside DECODE.
  task automatic garbage();
    logic [31:0] r;
    r = $urandom;
    {PCSel_d, ASel_d, BSel_d, DataRSel_d, ImmSel_d, DataWSel_d, WBSel_d, ALUSel_d} = r[16:0];
    RegWEn_d = r[17];
    MemRW_d  = r[18];
    illegal  = r[19];
  endtask

  task automatic tick_g();
    garbage();
    tick();
  endtask

  task automatic do_reset();
    m_bundle = 17'd0; m_ret = 4'd0; m_regwen = 1'b0; m_memrw = 1'b0;
    push(1'b1, 3'd0, 0, 1'b0, 2'd0);
    rst = 1'b1;
    tick_g();
    tick_g();
    rst = 1'b0;
  endtask

  // Called while the DUT sits in its first FETCH cycle.
  task automatic run_instr(input logic [16:0] b, input logic rw, input logic mw,
                           input int iw, input int dw, input logic ill);
    bit mem;
    imem_ready = 1'b0;
    dmem_ready = 1'b1;
    if (iw > MAXW) begin
      push(1'b0, 3'd7, MAXW + 1, 1'b1, 2'd2);
      repeat (MAXW + 1) tick_g();
      return;
    end
    push(1'b0, 3'd1, iw + 1, 1'b0, 2'd0);
    m_bundle = b; m_regwen = rw; m_memrw = mw;
    mem = mw || (b[5:4] == 2'd0);
    if (ill) begin
      push(1'b0, 3'd7, 1, 1'b1, 2'd1);
    end else begin
      push(1'b0, 3'd2, 1, 1'b0, 2'd0);
      if (mem) begin
        push(1'b0, 3'd3, 1, 1'b0, 2'd0);
        if (dw > MAXW) begin
          push(1'b0, 3'd7, MAXW + 1, 1'b1, 2'd3);
        end else begin
          push(1'b0, 3'd4, dw + 1, 1'b0, 2'd0);
          m_ret = m_ret + 4'd1;
          push(1'b0, 3'd0, 1, 1'b0, 2'd0);
        end
      end else begin
        push(1'b0, 3'd4, 1, 1'b0, 2'd0);
        m_ret = m_ret + 4'd1;
        push(1'b0, 3'd0, 1, 1'b0, 2'd0);
      end
    end
    repeat (iw) tick_g();
    imem_ready = 1'b1;
    tick_g();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    {PCSel_d, ASel_d, BSel_d, DataRSel_d, ImmSel_d, DataWSel_d, WBSel_d, ALUSel_d} = b;
    RegWEn_d = rw; MemRW_d = mw; illegal = ill;
    tick();
    if (ill) return;
    tick_g();
    if (mem) begin
      imem_ready = 1'b1;
      if (dw > MAXW) begin
        repeat (MAXW + 1) tick_g();
        return;
      end
      repeat (dw) tick_g();
      dmem_ready = 1'b1;
      tick_g();
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
    end
    tick_g();
  endtask

  task automatic hold_trap(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r = $urandom;
      imem_ready = r[0];
      dmem_ready = r[1];
      tick_g();
    end
  endtask

  logic rst_q = 1'b0;
  always @(posedge clk) rst_q <= rst;

  // Monitor: pops an expectation on each reset or state change, checks strobes every cycle.
  logic [2:0]  prev_state = 3'd0;
  logic [16:0] cur_bundle = 17'd0;
  logic        cur_regwen = 1'b0, cur_memrw = 1'b0;
  int          dwell = 0;
  bit          started = 0, in_rst = 0;
  initial begin
    exp_t e;
    logic [5:0] exp_s;
    forever begin
      @(negedge clk);
      if (rst_q || (started && state_o !== prev_state)) begin
        if (rst_q && in_rst) begin
          dwell = 1;
        end else if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_event: state %0h with empty queue at %0t", state_o, $time);
        end else begin
          e = q.pop_front();
          check("event_kind", {31'd0, rst_q}, {31'd0, e.is_reset});
          check("state", state_o, e.st);
          if (!rst_q) check("dwell", dwell, e.dwell);
          check("trap", trap, e.tr);
          check("trap_cause", trap_cause, e.cause);
          check("retired", retired, e.ret);
          check("bundle_at_event", act_bundle, e.bundle);
          cur_bundle = e.bundle; cur_regwen = e.regwen; cur_memrw = e.memrw;
        end
        in_rst = rst_q;
        started = 1;
        prev_state = state_o;
        dwell = 1;
      end else if (started) begin
        dwell++;
      end
      if (started) begin
        case (state_o)
          3'd0:    exp_s = {5'b10000, imem_ready};
          3'd3:    exp_s = {4'b0100, cur_memrw, 1'b0};
          3'd4:    exp_s = {3'b001, cur_regwen, 2'b00};
          default: exp_s = 6'd0;
        endcase
        check("strobes", {imem_req, dmem_req, pc_we, RegWEn, MemRW, ir_we}, exp_s);
        check("held_bundle", act_bundle, cur_bundle);
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic [16:0] b;
    do_reset();
    // ALU op, load/store, PC+4 writeback and the wait boundaries.
    run_instr({1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 2'd0, 2'd1, 4'd3}, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr({1'b0, 1'b1, 1'b1, 3'd2, 3'd2, 2'd2, 2'd2, 4'd0}, 1'b0, 1'b1, 2, 3, 1'b0);
    run_instr({1'b0, 1'b1, 1'b1, 3'd4, 3'd1, 2'd0, 2'd0, 4'd0}, 1'b1, 1'b0, 1, 0, 1'b0);
    run_instr({1'b1, 1'b1, 1'b0, 3'd0, 3'd3, 2'd0, 2'd2, 4'd0}, 1'b1, 1'b0, 3, 0, 1'b0);
    run_instr({1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 2'd1, 2'd1, 4'd7}, 1'b1, 1'b0, MAXW, 0, 1'b0);
    run_instr({1'b0, 1'b1, 1'b1, 3'd3, 3'd1, 2'd0, 2'd0, 4'd0}, 1'b1, 1'b0, 0, MAXW, 1'b0);
    // Enough retirements to wrap the 4-bit counter.
    for (int i = 0; i < 12; i++) begin
      r = $urandom;
      b = r[16:0];
      b[5:4] = (i % 2 == 0) ? 2'd1 : 2'd2;
      run_instr(b, r[20], 1'b0, i % 3, 0, 1'b0);
    end
    // Reset in the middle of a store's MEM wait.
    m_regwen = 1'b0;
    push(1'b0, 3'd1, 1, 1'b0, 2'd0);
    m_bundle = {1'b0, 1'b1, 1'b1, 3'd2, 3'd2, 2'd2, 2'd2, 4'd0};
    m_regwen = 1'b1; m_memrw = 1'b1;
    push(1'b0, 3'd2, 1, 1'b0, 2'd0);
    push(1'b0, 3'd3, 1, 1'b0, 2'd0);
    imem_ready = 1'b1;
    tick_g();
    imem_ready = 1'b0;
    {PCSel_d, ASel_d, BSel_d, DataRSel_d, ImmSel_d, DataWSel_d, WBSel_d, ALUSel_d} = m_bundle;
    RegWEn_d = 1'b1; MemRW_d = 1'b1; illegal = 1'b0;
    tick();
    tick_g();
    tick_g();
    tick_g();
    do_reset();
    // Illegal opcode, then imem and dmem timeouts; each held in TRAP then reset.
    run_instr({1'b1, 1'b0, 1'b1, 3'd5, 3'd4, 2'd3, 2'd1, 4'd9}, 1'b1, 1'b1, 1, 0, 1'b1);
    hold_trap(100);
    do_reset();
    run_instr({1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 2'd0, 2'd1, 4'd3}, 1'b1, 1'b0, MAXW + 1, 0, 1'b0);
    hold_trap(10);
    do_reset();
    run_instr({1'b0, 1'b1, 1'b1, 3'd2, 3'd2, 2'd2, 2'd2, 4'd0}, 1'b0, 1'b1, 0, MAXW + 1, 1'b0);
    hold_trap(10);
    do_reset();
    run_instr({1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 2'd0, 2'd1, 4'd5}, 1'b1, 1'b0, 0, 0, 1'b0);
    repeat (3) tick_g();
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
